// File: rtl/wb_regfile.sv
//============================================================================
// wb_regfile : MIPS writeback decode/extend + 32x32 GPR file with bypass
// Revision   : 1.0  initial release
//============================================================================
`default_nettype none

module wb_regfile #(
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ReadDataW,
    input  logic [31:0]      ALUOutW,
    input  logic [31:0]      PC8W,
    input  logic [31:0]      InsW,
    input  logic [4:0]       raddr1,
    input  logic [4:0]       raddr2,
    output logic [31:0]      rdata1,
    output logic [31:0]      rdata2,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] instret
);

    logic [5:0]       w_op;
    logic [5:0]       w_fn;
    logic [4:0]       w_rt;
    logic [4:0]       w_rd;
    logic             w_wr;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      r_regs [0:31];
    logic [CNT_W-1:0] r_instret;

    assign w_op   = InsW[31:26];
    assign w_fn   = InsW[5:0];
    assign w_rt   = InsW[20:16];
    assign w_rd   = InsW[15:11];
    assign w_byte = ReadDataW[{ALUOutW[1:0], 3'b000} +: 8];
    assign w_half = ALUOutW[1] ? ReadDataW[31:16] : ReadDataW[15:0];

    always_comb begin
        w_wr    = 1'b0;
        wb_addr = w_rt;
        wb_data = ALUOutW;
        case (w_op)
            6'h00: begin
                // jr, mthi/mtlo and mult/div family leave the GPRs alone
                if (!(w_fn == 6'h08 || w_fn == 6'h11 || w_fn == 6'h13 ||
                      (w_fn >= 6'h18 && w_fn <= 6'h1B))) begin
                    w_wr    = 1'b1;
                    wb_addr = w_rd;
                    if (w_fn == 6'h09)
                        wb_data = PC8W;
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F: w_wr = 1'b1;
            6'h03: begin
                w_wr    = 1'b1;
                wb_addr = 5'd31;
                wb_data = PC8W;
            end
            6'h23: begin
                w_wr    = 1'b1;
                wb_data = ReadDataW;
            end
            6'h20: begin
                w_wr    = 1'b1;
                wb_data = {{24{w_byte[7]}}, w_byte};
            end
            6'h24: begin
                w_wr    = 1'b1;
                wb_data = {24'd0, w_byte};
            end
            6'h21: begin
                w_wr    = 1'b1;
                wb_data = {{16{w_half[15]}}, w_half};
            end
            6'h25: begin
                w_wr    = 1'b1;
                wb_data = {16'd0, w_half};
            end
            default: w_wr = 1'b0;
        endcase
    end

    assign wb_we = w_wr && (wb_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= 32'd0;
            r_instret <= '0;
        end else begin
            if (wb_we)
                r_regs[wb_addr] <= wb_data;
            if (InsW != 32'd0)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign instret = r_instret;

    always_comb begin
        if (raddr1 == 5'd0)
            rdata1 = 32'd0;
        else if (BYPASS && wb_we && (wb_addr == raddr1))
            rdata1 = wb_data;
        else
            rdata1 = r_regs[raddr1];
    end

    always_comb begin
        if (raddr2 == 5'd0)
            rdata2 = 32'd0;
        else if (BYPASS && wb_we && (wb_addr == raddr2))
            rdata2 = wb_data;
        else
            rdata2 = r_regs[raddr2];
    end

endmodule

`default_nettype wire
